// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: output-stationary ROWSxCOLS multiply-accumulate grid with skewed operand fetch and row-major result drain.
// Build option: define SA_SATURATE_EN to clamp accumulators at 2^ACC_WIDTH-1 instead of wrapping.
module systolic_array_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int K_DEPTH    = 3
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  start,
  input  logic [ROWS*DATA_WIDTH-1:0]                            a_data,
  input  logic [COLS*DATA_WIDTH-1:0]                            b_data,
  output logic [ROWS-1:0]                                       a_rd_en,
  output logic [COLS-1:0]                                       b_rd_en,
  output logic [ACC_WIDTH-1:0]                                  c_data,
  output logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0]  c_index,
  output logic                                                  c_valid,
  input  logic                                                  c_ready,
  output logic                                                  busy,
  output logic                                                  done
);

  localparam int NRES        = ROWS * COLS;
  localparam int IDX_W       = (NRES > 1) ? $clog2(NRES) : 1;
  localparam int COMPUTE_LEN = K_DEPTH + ROWS + COLS - 2;
  localparam int T_W         = $clog2(COMPUTE_LEN + 1);
  localparam int SUM_W       = ((2*DATA_WIDTH > ACC_WIDTH) ? 2*DATA_WIDTH : ACC_WIDTH) + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]            state;
  logic [T_W-1:0]        t;
  logic [IDX_W-1:0]      idx;
  logic                  done_r;
  logic [ACC_WIDTH-1:0]  acc   [NRES];
  logic [DATA_WIDTH-1:0] a_op  [NRES];
  logic [DATA_WIDTH-1:0] b_op  [NRES];
  logic [DATA_WIDTH-1:0] a_fwd [NRES];
  logic [DATA_WIDTH-1:0] b_fwd [NRES];

  // The comparison uses the full, untruncated product so a single oversized
  // product saturates even if its low ACC_WIDTH bits would not overflow.
  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0]  acc_in,
                                                   input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [2*DATA_WIDTH-1:0] prod;
`ifdef SA_SATURATE_EN
    logic [SUM_W-1:0] sum;
`endif
    prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
`ifdef SA_SATURATE_EN
    sum = SUM_W'(acc_in) + SUM_W'(prod);
    if (sum > SUM_W'(ACC_MAX)) return ACC_MAX;
    return ACC_WIDTH'(sum);
`else
    return ACC_WIDTH'(SUM_W'(acc_in) + SUM_W'(prod));
`endif
  endfunction

  // Lane i is live for K_DEPTH cycles starting at t=i, giving the diagonal skew.
  always_comb begin
    a_rd_en = '0;
    b_rd_en = '0;
    for (int i = 0; i < ROWS; i++)
      a_rd_en[i] = (state == S_COMPUTE) && (int'(t) >= i) && (int'(t) < i + K_DEPTH);
    for (int j = 0; j < COLS; j++)
      b_rd_en[j] = (state == S_COMPUTE) && (int'(t) >= j) && (int'(t) < j + K_DEPTH);
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_op[i*COLS+j] = a_rd_en[i] ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      end else begin : g_a_inner
        assign a_op[i*COLS+j] = a_fwd[i*COLS+j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_op[i*COLS+j] = b_rd_en[j] ? b_data[j*DATA_WIDTH +: DATA_WIDTH] : '0;
      end else begin : g_b_inner
        assign b_op[i*COLS+j] = b_fwd[(i-1)*COLS+j];
      end
    end
  end

  // Operand forwarding stage: A moves one PE right, B one PE down per cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NRES; k++) begin
      if (state == S_IDLE && start) begin
        a_fwd[k] <= '0;
        b_fwd[k] <= '0;
      end else if (state == S_COMPUTE) begin
        a_fwd[k] <= a_op[k];
        b_fwd[k] <= b_op[k];
      end
    end
  end

  // Accumulate stage; values persist through DRAIN and IDLE until the next job.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NRES; k++) begin
      if (rst || (state == S_IDLE && start)) acc[k] <= '0;
      else if (state == S_COMPUTE)           acc[k] <= acc_add(acc[k], a_op[k], b_op[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      t      <= '0;
      idx    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_COMPUTE;
          t     <= '0;
          idx   <= '0;
        end
        S_COMPUTE: begin
          if (t == T_W'(COMPUTE_LEN - 1)) state <= S_DRAIN;
          else                            t     <= t + 1'b1;
        end
        S_DRAIN: if (c_ready) begin
          if (idx == IDX_W'(NRES - 1)) begin
            state  <= S_IDLE;
            idx    <= '0;
            done_r <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign c_valid = (state == S_DRAIN);
  assign c_index = idx;
  assign c_data  = (state == S_DRAIN) ? acc[idx] : '0;
  assign busy    = (state != S_IDLE);
  assign done    = done_r;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench for systolic_array_ctrl: a 3x3 K=3 engine, a 2x4 K=5 engine and a 1x1 K=2 32-bit accumulator engine.
module tb_systolic_array_ctrl;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

`ifdef SA_SATURATE_EN
  localparam logic [63:0] BIG3 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [31:0] SMALL2 = 32'hFFFF_FFFF;
`else
  localparam logic [63:0] BIG3 = 64'hFFFF_FFFA_0000_0003;
  localparam logic [31:0] SMALL2 = 32'h0000_0002;
`endif

  // ---------------- DUT0: 3x3, K=3, 32/64 ----------------
  logic          start0, c_ready0, c_valid0, busy0, done0;
  logic [3*DW-1:0] a_data0, b_data0;
  logic [2:0]    a_en0, b_en0;
  logic [63:0]   c_data0;
  logic [3:0]    c_index0;

  systolic_array_ctrl #(.DATA_WIDTH(32), .ACC_WIDTH(64), .ROWS(3), .COLS(3), .K_DEPTH(3)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a_data(a_data0), .b_data(b_data0),
    .a_rd_en(a_en0), .b_rd_en(b_en0), .c_data(c_data0), .c_index(c_index0),
    .c_valid(c_valid0), .c_ready(c_ready0), .busy(busy0), .done(done0));

  logic [DW-1:0] mat_a [3][3];
  logic [DW-1:0] mat_b [3][3];
  int pa [3];
  int pb [3];

  // Operand memories: disabled lanes carry garbage so missing zero padding shows up.
  always_comb begin
    a_data0 = '0;
    b_data0 = '0;
    for (int i = 0; i < 3; i++) begin
      a_data0[i*DW +: DW] = (a_en0[i] && pa[i] < 3) ? mat_a[i][pa[i]] : 32'hDEAD_BEEF;
      b_data0[i*DW +: DW] = (b_en0[i] && pb[i] < 3) ? mat_b[pb[i]][i] : 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || (start0 && !busy0)) begin
        pa[i] <= 0;
        pb[i] <= 0;
      end else begin
        if (a_en0[i]) pa[i] <= pa[i] + 1;
        if (b_en0[i]) pb[i] <= pb[i] + 1;
      end
    end
  end

  logic [63:0] exp_d0 [$];
  int          exp_i0 [$];
  int fv_cyc, lh_cyc, done_cyc, st_cyc;
  int done_cnt0 = 0;
  bit pv0 = 0, hold0 = 0;
  logic [63:0] hd0;
  logic [3:0]  hi0;
  logic [63:0] ed0;
  int          ei0;

  // Monitor for DUT0: scoreboard pops, hold stability, timing stamps.
  always @(negedge clk) begin
    if (!rst) begin
      if (c_valid0 && !pv0) fv_cyc = cyc;
      if (hold0 && c_valid0) begin
        check("hold_data", c_data0, hd0);
        check("hold_index", 64'(c_index0), 64'(hi0));
      end
      if (c_valid0 && c_ready0) begin
        if (exp_d0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0_unexpected: got index %0d data %h, expected no result", c_index0, c_data0);
        end else begin
          ed0 = exp_d0.pop_front();
          ei0 = exp_i0.pop_front();
          check("dut0_data", c_data0, ed0);
          check("dut0_index", 64'(c_index0), 64'(ei0));
        end
        if (c_index0 == 4'd8) lh_cyc = cyc;
      end
      if (done0) begin
        done_cnt0++;
        done_cyc = cyc;
      end
      hold0 = c_valid0 && !c_ready0;
      hd0   = c_data0;
      hi0   = c_index0;
      pv0   = c_valid0;
    end else begin
      hold0 = 0;
      pv0   = 0;
    end
  end

  task automatic load0(input int sel);
    logic [63:0] e1 [9];
    e1 = '{64'd30, 64'd24, 64'd18, 64'd84, 64'd69, 64'd54, 64'd138, 64'd114, 64'd90};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        case (sel)
          0: begin mat_a[r][c] = (r == c) ? 32'd1 : 32'd0; mat_b[r][c] = 32'(r*3 + c + 1); end
          1: begin mat_a[r][c] = 32'(r*3 + c + 1);         mat_b[r][c] = 32'(9 - (r*3 + c)); end
          default: begin mat_a[r][c] = 32'hFFFF_FFFF;      mat_b[r][c] = 32'hFFFF_FFFF; end
        endcase
      end
    for (int k = 0; k < 9; k++) begin
      case (sel)
        0: exp_d0.push_back(64'(k + 1));
        1: exp_d0.push_back(e1[k]);
        default: exp_d0.push_back(BIG3);
      endcase
      exp_i0.push_back(k);
    end
  endtask

  // Called at negedge+1; returns in the first COMPUTE cycle at posedge+1.
  task automatic issue0();
    start0 = 1'b1;
    st_cyc = cyc;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("busy_after_start", 64'(busy0), 64'd1);
    check("a_en_t0", 64'(a_en0), 64'b001);
    check("b_en_t0", 64'(b_en0), 64'b001);
  endtask

  // mode 0: ready held high; 1: ready 1,0,0 repeating; 2: ready high with stray start pulses.
  task automatic run0(input int mode);
    for (int n = 0; n < 200; n++) begin
      c_ready0 = (mode == 1) ? (n % 3 == 0) : 1'b1;
      start0   = (mode == 2) && (n == 3 || n == 8);
      @(posedge clk); #1;
      if (done0) begin
        start0 = 1'b0;
        return;
      end
    end
    start0 = 1'b0;
    checks++; errors++;
    $display("FAIL dut0_job_timeout: got no done within 200 cycles, expected done");
  endtask

  task automatic post0(input int exp_done, input bit full_rate);
    @(negedge clk); #1;
    check("queue_drained", 64'(exp_d0.size()), 64'd0);
    check("done_count", 64'(done_cnt0), 64'(exp_done));
    check("done_after_last", 64'(done_cyc - lh_cyc), 64'd1);
    check("first_valid_latency", 64'(fv_cyc - st_cyc), 64'd8);
    if (full_rate) check("drain_cycles", 64'(lh_cyc - fv_cyc), 64'd8);
    check("idle_in_done_cycle", 64'(busy0), 64'd0);
  endtask

  // ---------------- DUT1: 2x4, K=5 ----------------
  logic          start1, c_valid1, busy1, done1;
  logic          c_ready1 = 1'b1;
  logic [2*DW-1:0] a_data1;
  logic [4*DW-1:0] b_data1;
  logic [1:0]    a_en1;
  logic [3:0]    b_en1;
  logic [63:0]   c_data1;
  logic [2:0]    c_index1;

  systolic_array_ctrl #(.DATA_WIDTH(32), .ACC_WIDTH(64), .ROWS(2), .COLS(4), .K_DEPTH(5)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_data(a_data1), .b_data(b_data1),
    .a_rd_en(a_en1), .b_rd_en(b_en1), .c_data(c_data1), .c_index(c_index1),
    .c_valid(c_valid1), .c_ready(c_ready1), .busy(busy1), .done(done1));

  always_comb begin
    a_data1 = '0;
    b_data1 = '0;
    for (int i = 0; i < 2; i++) a_data1[i*DW +: DW] = a_en1[i] ? 32'd2 : 32'hBAD0_0001;
    for (int j = 0; j < 4; j++) b_data1[j*DW +: DW] = b_en1[j] ? 32'd3 : 32'hBAD0_0002;
  end

  logic [63:0] exp_d1 [$];
  int          exp_i1 [$];
  logic [63:0] ed1;
  int          ei1;

  always @(negedge clk) begin
    if (!rst && c_valid1 && c_ready1) begin
      if (exp_d1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected: got index %0d data %h, expected no result", c_index1, c_data1);
      end else begin
        ed1 = exp_d1.pop_front();
        ei1 = exp_i1.pop_front();
        check("dut1_data", c_data1, ed1);
        check("dut1_index", 64'(c_index1), 64'(ei1));
      end
    end
  end

  // ---------------- DUT2: 1x1, K=2, 32-bit accumulator ----------------
  logic          start2, c_valid2, busy2, done2;
  logic          c_ready2 = 1'b1;
  logic [DW-1:0] a_data2, b_data2;
  logic [0:0]    a_en2, b_en2;
  logic [31:0]   c_data2;
  logic [0:0]    c_index2;

  systolic_array_ctrl #(.DATA_WIDTH(32), .ACC_WIDTH(32), .ROWS(1), .COLS(1), .K_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_data(a_data2), .b_data(b_data2),
    .a_rd_en(a_en2), .b_rd_en(b_en2), .c_data(c_data2), .c_index(c_index2),
    .c_valid(c_valid2), .c_ready(c_ready2), .busy(busy2), .done(done2));

  assign a_data2 = a_en2[0] ? 32'hFFFF_FFFF : 32'h1234_5678;
  assign b_data2 = b_en2[0] ? 32'hFFFF_FFFF : 32'h1234_5678;

  logic [31:0] exp_d2 [$];
  logic [31:0] ed2;

  always @(negedge clk) begin
    if (!rst && c_valid2 && c_ready2) begin
      if (exp_d2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_unexpected: got data %h, expected no result", c_data2);
      end else begin
        ed2 = exp_d2.pop_front();
        check("dut2_data", 64'(c_data2), 64'(ed2));
        check("dut2_index", 64'(c_index2), 64'd0);
      end
    end
  end

  task automatic wait_done_other(input int which, input string name);
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if ((which == 1 && done1) || (which == 2 && done2)) return;
    end
    checks++; errors++;
    $display("FAIL %s: got no done within 60 cycles, expected done", name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  int dn;

  initial begin
    rst = 1'b1; start0 = 1'b0; c_ready0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_c_valid", 64'(c_valid0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_c_data", c_data0, 64'd0);
    check("rst_c_index", 64'(c_index0), 64'd0);
    check("rst_enables", 64'({a_en0, b_en0}), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Identity times 1..9 at full rate.
    load0(0); issue0(); run0(0); post0(1, 1'b1);
    // Backpressure with a dense product.
    load0(1); issue0(); run0(1); post0(2, 1'b0);
    // Wrap-around operands, stray starts during COMPUTE and DRAIN.
    load0(2); issue0(); run0(2); post0(3, 1'b1);
    // New start issued in the done cycle.
    check("done_cycle_for_restart", 64'(done0), 64'd1);
    load0(0); issue0(); run0(0); post0(4, 1'b1);

    // Reset while presenting index 4.
    load0(1); issue0();
    c_ready0 = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (c_valid0 && c_index0 == 4'd4) break;
    end
    check("reached_index4", 64'(c_index0), 64'd4);
    rst = 1'b1; c_ready0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_c_valid", 64'(c_valid0), 64'd0);
    check("midrst_busy", 64'(busy0), 64'd0);
    check("midrst_done", 64'(done0), 64'd0);
    check("midrst_c_data", c_data0, 64'd0);
    check("midrst_c_index", 64'(c_index0), 64'd0);
    check("midrst_enables", 64'({a_en0, b_en0}), 64'd0);
    exp_d0.delete();
    exp_i0.delete();
    dn = done_cnt0;
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    check("midrst_no_done", 64'(done_cnt0), 64'(dn));
    load0(0); issue0(); run0(0); post0(5, 1'b1);

    // 2x4, K=5: all results 30, lane enable windows.
    for (int k = 0; k < 8; k++) begin
      exp_d1.push_back(64'd30);
      exp_i1.push_back(k);
    end
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int t = 0; t < 9; t++) begin
      check("dut1_a_en1", 64'(a_en1[1]), 64'(t >= 1 && t <= 5));
      check("dut1_b_en3", 64'(b_en1[3]), 64'(t >= 3 && t <= 7));
      @(posedge clk); #1;
    end
    check("dut1_valid_after_compute", 64'(c_valid1), 64'd1);
    wait_done_other(1, "dut1_job_timeout");
    @(negedge clk); #1;
    check("dut1_queue_drained", 64'(exp_d1.size()), 64'd0);

    // 1x1, K=2, 32-bit accumulator with all-ones operands.
    exp_d2.push_back(SMALL2);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("dut2_en_t0", 64'({a_en2, b_en2}), 64'b11);
    wait_done_other(2, "dut2_job_timeout");
    @(negedge clk); #1;
    check("dut2_queue_drained", 64'(exp_d2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
